// File: rtl/iod_delay_tap_ctrl.sv
// Tap-adjust sequencer for the DDR3 address/command IOD delay lines.
// One command at a time: strobes LOAD/MOVE with setup and settle spacing and tracks a shadow tap per lane.
module iod_delay_tap_ctrl #(
  parameter int NUM_LANES     = 14,
  parameter int MAX_TAP       = 255,
  parameter int LOAD_TAP      = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [$clog2(NUM_LANES)-1:0] CMD_LANE,
  input  logic [1:0]                   CMD_OP,
  input  logic [7:0]                   CMD_STEPS,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
  output logic                         DONE,
  output logic                         RESP_OOR,
  output logic                         RESP_ERR,
  output logic [7:0]                   RESP_STEPS,
  output logic [7:0]                   RESP_TAP
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    MAX_V       = 8'(MAX_TAP);
  localparam logic [7:0]    LOAD_V      = 8'(LOAD_TAP);
  localparam logic [1:0]    OP_LOAD     = 2'b00;
  localparam logic [1:0]    OP_INC      = 2'b01;
  localparam logic [1:0]    OP_DEC      = 2'b10;
  localparam logic [1:0]    OP_RSV      = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t                 state_q;
  logic [LW-1:0]          lane_q;
  logic [1:0]             op_q;
  logic [7:0]             steps_q;
  logic [7:0]             cnt_q;
  logic [SW-1:0]          settle_q;
  logic [7:0]             shadow_q [NUM_LANES];
  logic                   ready_q;
  logic                   done_q;
  logic [NUM_LANES-1:0]   load_q;
  logic [NUM_LANES-1:0]   move_q;
  logic [NUM_LANES-1:0]   dir_q;
  logic                   resp_oor_q;
  logic                   resp_err_q;
  logic [7:0]             resp_steps_q;
  logic [7:0]             resp_tap_q;

  logic [NUM_LANES-1:0]   lane_oh;
  logic [NUM_LANES-1:0]   cmd_oh;
  logic [7:0]             tap_cur;
  logic [7:0]             tap_nxt;
  logic [7:0]             cmd_tap;
  logic [7:0]             cnt_nxt;
  logic                   lane_oor;
  logic                   cmd_lane_bad;
  logic                   at_limit;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_onehot
      assign lane_oh[gi] = (lane_q == LW'(gi));
      assign cmd_oh[gi]  = (CMD_LANE == LW'(gi));
    end
  endgenerate

  // Shadow/flag lookup by compare loop so an illegal lane simply reads as zero.
  always_comb begin
    tap_cur  = '0;
    cmd_tap  = '0;
    lane_oor = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_oh[i]) begin
        tap_cur  = shadow_q[i];
        lane_oor = DELAY_LINE_OUT_OF_RANGE[i];
      end
      if (cmd_oh[i]) begin
        cmd_tap = shadow_q[i];
      end
    end
  end

  assign tap_nxt      = (op_q == OP_INC) ? (tap_cur + 8'd1) : (tap_cur - 8'd1);
  assign cnt_nxt      = cnt_q + 8'd1;
  assign cmd_lane_bad = ({1'b0, CMD_LANE} >= (LW + 1)'(NUM_LANES));
  assign at_limit     = ((op_q == OP_INC) && (tap_cur == MAX_V)) ||
                        ((op_q == OP_DEC) && (tap_cur == 8'd0));

  always_ff @(posedge FAB_CLK) begin
    if (!ARST_N) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      op_q         <= OP_LOAD;
      steps_q      <= '0;
      cnt_q        <= '0;
      settle_q     <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      load_q       <= '0;
      move_q       <= '0;
      dir_q        <= '0;
      resp_oor_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_steps_q <= '0;
      resp_tap_q   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        shadow_q[i] <= LOAD_V;
      end
    end else begin
      done_q <= 1'b0;
      load_q <= '0;
      move_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID && ready_q) begin
            lane_q       <= CMD_LANE;
            op_q         <= CMD_OP;
            steps_q      <= CMD_STEPS;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_oor_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_steps_q <= '0;
            resp_tap_q   <= '0;
            if (cmd_lane_bad || (CMD_OP == OP_RSV)) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              resp_err_q <= 1'b1;
            end else if (CMD_OP == OP_LOAD) begin
              state_q <= S_LOAD;
              load_q  <= cmd_oh;
            end else if (CMD_STEPS == 8'd0) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              resp_tap_q <= cmd_tap;
            end else begin
              state_q <= S_SETUP;
              dir_q   <= (CMD_OP == OP_INC) ? cmd_oh : '0;
            end
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_oh[i]) shadow_q[i] <= LOAD_V;
          end
          settle_q <= SETTLE_INIT;
          state_q  <= S_SETTLE;
        end
        S_SETUP: begin
          // A step that would leave the legal tap range is refused before any pulse.
          if (at_limit) begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            dir_q        <= '0;
            resp_oor_q   <= 1'b1;
            resp_steps_q <= cnt_q;
            resp_tap_q   <= tap_cur;
          end else begin
            move_q  <= lane_oh;
            state_q <= S_PULSE;
          end
        end
        S_PULSE: begin
          settle_q <= SETTLE_INIT;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (op_q == OP_LOAD) begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            resp_oor_q   <= lane_oor;
            resp_tap_q   <= tap_cur;
          end else if (lane_oor) begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            dir_q        <= '0;
            resp_oor_q   <= 1'b1;
            resp_steps_q <= cnt_q;
            resp_tap_q   <= tap_cur;
          end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (lane_oh[i]) shadow_q[i] <= tap_nxt;
            end
            cnt_q <= cnt_nxt;
            if (cnt_nxt < steps_q) begin
              state_q <= S_SETUP;
            end else begin
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              dir_q        <= '0;
              resp_steps_q <= cnt_nxt;
              resp_tap_q   <= tap_nxt;
            end
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          dir_q   <= '0;
        end
      endcase
    end
  end

  assign CMD_READY            = ready_q;
  assign DONE                 = done_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign RESP_OOR             = resp_oor_q;
  assign RESP_ERR             = resp_err_q;
  assign RESP_STEPS           = resp_steps_q;
  assign RESP_TAP             = resp_tap_q;

endmodule

// File: tb/tb_iod_delay_tap_ctrl.sv
// Directed bench for iod_delay_tap_ctrl: timing of strobes/DONE and response fields per command.
module tb_iod_delay_tap_ctrl;
  localparam int NL = 14;

  logic          FAB_CLK;
  logic          ARST_N;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [3:0]    CMD_LANE;
  logic [1:0]    CMD_OP;
  logic [7:0]    CMD_STEPS;
  logic [NL-1:0] dl_load;
  logic [NL-1:0] dl_move;
  logic [NL-1:0] dl_dir;
  logic [NL-1:0] dl_oor;
  logic          DONE;
  logic          RESP_OOR;
  logic          RESP_ERR;
  logic [7:0]    RESP_STEPS;
  logic [7:0]    RESP_TAP;

  int checks = 0;
  int fails  = 0;
  int done_off, n_load, load_off, bad_strobe, dir_bad;
  int move_offs[$];
  int r_steps, r_tap, r_oor, r_err;

  iod_delay_tap_ctrl #(
    .NUM_LANES(14), .MAX_TAP(255), .LOAD_TAP(1), .SETTLE_CYCLES(4)
  ) dut (
    .FAB_CLK(FAB_CLK),
    .ARST_N(ARST_N),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_LANE(CMD_LANE),
    .CMD_OP(CMD_OP),
    .CMD_STEPS(CMD_STEPS),
    .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor),
    .DONE(DONE),
    .RESP_OOR(RESP_OOR),
    .RESP_ERR(RESP_ERR),
    .RESP_STEPS(RESP_STEPS),
    .RESP_TAP(RESP_TAP)
  );

  initial begin
    FAB_CLK = 1'b0;
    forever #5 FAB_CLK = ~FAB_CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command from a sample point (1ns after an edge); offset j = j-th sample after the accept edge.
  task automatic run_cmd(input int lane, input int op, input int steps, input int oor_off, input int budget);
    logic [NL-1:0] oh;
    logic          exp_dir;
    oh      = (lane < NL) ? (NL'(1) << lane) : '0;
    exp_dir = (op == 1);
    chk("ready_before_cmd", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1;
    CMD_LANE  = 4'(lane);
    CMD_OP    = 2'(op);
    CMD_STEPS = 8'(steps);
    done_off = -1; n_load = 0; load_off = -1; bad_strobe = 0; dir_bad = 0;
    move_offs.delete();
    r_steps = -1; r_tap = -1; r_oor = -1; r_err = -1;
    for (int j = 1; j <= budget; j++) begin
      @(posedge FAB_CLK);
      #1;
      CMD_VALID = 1'b0;
      if ($countones(dl_move | dl_load) > 1) bad_strobe++;
      if (((dl_move | dl_load | dl_dir) & ~oh) != '0) bad_strobe++;
      if (lane < NL) begin
        if (dl_move[lane]) move_offs.push_back(j);
        if (dl_load[lane]) begin
          n_load++;
          load_off = j;
        end
        if (!DONE && (dl_dir[lane] !== exp_dir)) dir_bad++;
      end
      if (DONE) begin
        done_off = j;
        r_steps = int'(RESP_STEPS);
        r_tap   = int'(RESP_TAP);
        r_oor   = int'(RESP_OOR);
        r_err   = int'(RESP_ERR);
        break;
      end
      if (oor_off > 0 && lane < NL) dl_oor[lane] = (j == oor_off - 1) || (j == oor_off);
    end
    dl_oor = '0;
    $display("cmd lane=%0d op=%0d steps=%0d done@%0d moves=%0d loads=%0d resp_steps=%0d tap=%0d oor=%0d err=%0d",
             lane, op, steps, done_off, move_offs.size(), n_load, r_steps, r_tap, r_oor, r_err);
    if (done_off > 0) begin
      @(posedge FAB_CLK);
      #1;
      chk("done_one_cycle", 32'(DONE), 32'd0);
      chk("ready_after_done", 32'(CMD_READY), 32'd1);
    end
  endtask

  initial begin
    ARST_N = 1'b0; CMD_VALID = 1'b0; CMD_LANE = '0; CMD_OP = '0; CMD_STEPS = '0; dl_oor = '0;
    repeat (3) @(posedge FAB_CLK);
    #1;
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_strobes", 32'(dl_move | dl_load | dl_dir), 32'd0);
    chk("rst_resp", {RESP_STEPS, RESP_TAP, 14'd0, RESP_OOR, RESP_ERR}, 32'd0);
    ARST_N = 1'b1;

    // INC lane 3 by 3
    run_cmd(3, 1, 3, 0, 40);
    chk("inc3_done_off", 32'(done_off), 32'd22);
    chk("inc3_moves", 32'(move_offs.size()), 32'd3);
    if (move_offs.size() == 3) begin
      chk("inc3_move1", 32'(move_offs[0]), 32'd2);
      chk("inc3_move2", 32'(move_offs[1]), 32'd9);
      chk("inc3_move3", 32'(move_offs[2]), 32'd16);
    end
    chk("inc3_dir", 32'(dir_bad), 32'd0);
    chk("inc3_onehot", 32'(bad_strobe), 32'd0);
    chk("inc3_steps", 32'(r_steps), 32'd3);
    chk("inc3_tap", 32'(r_tap), 32'd4);
    chk("inc3_oor", 32'(r_oor), 32'd0);
    chk("inc3_err", 32'(r_err), 32'd0);

    // INC lane 0 by 10, LOAD, DEC 1
    run_cmd(0, 1, 10, 0, 100);
    chk("inc10_done_off", 32'(done_off), 32'd71);
    chk("inc10_tap", 32'(r_tap), 32'd11);
    run_cmd(0, 0, 0, 0, 20);
    chk("load_strobe_off", 32'(load_off), 32'd1);
    chk("load_strobe_cnt", 32'(n_load), 32'd1);
    chk("load_done_off", 32'(done_off), 32'd7);
    chk("load_tap", 32'(r_tap), 32'd1);
    chk("load_oor", 32'(r_oor), 32'd0);
    chk("load_nomove", 32'(move_offs.size()), 32'd0);
    run_cmd(0, 2, 1, 0, 20);
    chk("dec1_done_off", 32'(done_off), 32'd8);
    chk("dec1_tap", 32'(r_tap), 32'd0);
    chk("dec1_dir", 32'(dir_bad), 32'd0);

    // DEC lane 5 by 2 from 1: second SETUP refuses
    run_cmd(5, 2, 2, 0, 30);
    chk("dec2_done_off", 32'(done_off), 32'd9);
    chk("dec2_moves", 32'(move_offs.size()), 32'd1);
    chk("dec2_steps", 32'(r_steps), 32'd1);
    chk("dec2_tap", 32'(r_tap), 32'd0);
    chk("dec2_oor", 32'(r_oor), 32'd1);

    // INC lane 7 by 5, OUT_OF_RANGE at 3rd CHECK (offset 21), also high in the SETTLE before it
    run_cmd(7, 1, 5, 21, 50);
    chk("oor7_done_off", 32'(done_off), 32'd22);
    chk("oor7_moves", 32'(move_offs.size()), 32'd3);
    chk("oor7_steps", 32'(r_steps), 32'd2);
    chk("oor7_tap", 32'(r_tap), 32'd3);
    chk("oor7_oor", 32'(r_oor), 32'd1);

    // Zero-step INC reports current shadow
    run_cmd(7, 1, 0, 0, 10);
    chk("zero_done_off", 32'(done_off), 32'd1);
    chk("zero_tap", 32'(r_tap), 32'd3);
    chk("zero_err", 32'(r_err), 32'd0);

    // Illegal lane, then reserved op
    run_cmd(14, 1, 1, 0, 10);
    chk("badlane_done_off", 32'(done_off), 32'd1);
    chk("badlane_err", 32'(r_err), 32'd1);
    chk("badlane_strobes", 32'(bad_strobe), 32'd0);
    run_cmd(2, 3, 1, 0, 10);
    chk("rsvop_done_off", 32'(done_off), 32'd1);
    chk("rsvop_err", 32'(r_err), 32'd1);
    chk("rsvop_strobes", 32'(bad_strobe + n_load + move_offs.size() + dir_bad), 32'd0);

    // INC lane 12 to the top: 254 steps then refusal
    run_cmd(12, 1, 255, 0, 2000);
    chk("max_done_off", 32'(done_off), 32'd1780);
    chk("max_moves", 32'(move_offs.size()), 32'd254);
    chk("max_steps", 32'(r_steps), 32'd254);
    chk("max_tap", 32'(r_tap), 32'd255);
    chk("max_oor", 32'(r_oor), 32'd1);
    chk("max_dir", 32'(dir_bad), 32'd0);

    // Reset during 2nd SETTLE of INC 4 on lane 9
    run_cmd(9, 1, 4, 0, 11);
    chk("rstmid_no_done", 32'(done_off), 32'hFFFF_FFFF);
    chk("rstmid_dir_before", 32'(dl_dir[9]), 32'd1);
    ARST_N = 1'b0;
    @(posedge FAB_CLK);
    #1;
    chk("rstmid_strobes", 32'(dl_move | dl_load | dl_dir), 32'd0);
    chk("rstmid_ready", 32'(CMD_READY), 32'd1);
    chk("rstmid_done", 32'(DONE), 32'd0);
    chk("rstmid_resp_tap", 32'(RESP_TAP), 32'd0);
    ARST_N = 1'b1;
    run_cmd(9, 1, 1, 0, 20);
    chk("rstmid_inc9_tap", 32'(r_tap), 32'd2);
    chk("rstmid_inc9_done_off", 32'(done_off), 32'd8);
    run_cmd(3, 1, 1, 0, 20);
    chk("rstmid_inc3_tap", 32'(r_tap), 32'd2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
